multdiv_ctrl: RTL
=================

Name: multdiv_ctrl

Overview:
Sequencing controller for the iterative multiply/divide unit in the decode stage of the MIPS core. Replaces the single-cycle `multdiv` enable with a parametrised, latency-aware handshake.
- Accepts MULT/MULTU/DIV/DIVU and issues a start pulse to the HI/LO datapath.
- Counts the per-operation latency and issues a single HI/LO commit.
- Stalls any HI/LO-touching instruction until the result has committed.

Parameters:
MULT_CYCLES, 4, cycles from md_start to hilo_commit for MULT/MULTU; must be ≥1
DIV_CYCLES, 32, cycles from md_start to hilo_commit for DIV/DIVU; must be ≥1
CNT_W, $clog2(max(MULT_CYCLES,DIV_CYCLES)+1), latency counter width (derived; do not override)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  decode-stage instruction valid
opcode  in  6  instruction[31:26]
function_code  in  6  instruction[5:0]
early_out  in  1  datapath flag: a multiply operand is zero or the divisor is zero
flush  in  1  synchronous pipeline flush; aborts the in-flight operation
md_start  out  1  one-cycle start pulse to the mult/div datapath
op_signed  out  1  latched: 1 for MULT/DIV, 0 for MULTU/DIVU
op_div  out  1  latched: 1 for DIV/DIVU
busy  out  1  operation in flight
stall  out  1  hold the fetch/decode stages
hilo_commit  out  1  one-cycle write enable for HI and LO from the datapath result

Behaviour:
Interface:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Assertion of rst_n=0 forces the following immediately, regardless of state (including mid-operation; no commit is issued):
  - state=IDLE, counter=0
  - op_signed=0, op_div=0
  - md_start=0, busy=0, stall=0, hilo_commit=0

Decode (all decode terms require opcode==0):
- is_md: function_code ∈ {24,25,26,27}
- is_hilo: is_md, or function_code ∈ {16,17,18,19} (MFHI/MTHI/MFLO/MTLO)

FSM states: IDLE, BUSY.

IDLE:
- accept = valid_in & is_md & ~flush.
- On accept:
  - md_start=1 (combinational, same cycle).
  - Register op_signed = (function_code==24 | function_code==26).
  - Register op_div = function_code[1].
  - Load counter = (op_div ? DIV_CYCLES : MULT_CYCLES) - 1.
  - Next state = BUSY.
- Non-md instructions pass through; stall=0.

BUSY:
- busy=1.
- If counter≠0: decrement by 1.
- If counter==0: hilo_commit=1 (combinational), next state = IDLE.
- Latency: hilo_commit occurs exactly MULT_CYCLES or DIV_CYCLES cycles after the md_start cycle.
- stall = valid_in & is_hilo, including on the commit cycle. HI/LO are written at that edge, so MFHI/MFLO read them the following cycle.
- Instructions that are not HI/LO-related never stall.
- A new mult/div arriving on the commit cycle is stalled and accepted in the next (IDLE) cycle. There are no back-to-back starts without one idle cycle.

Flush:
- flush=1 in BUSY: next state = IDLE, counter cleared, no hilo_commit.
  - flush on the commit cycle itself suppresses hilo_commit.
- flush=1 in IDLE blocks accept.

Outputs and counter:
- op_signed and op_div hold their values until the next accept.
- Counter never wraps; it saturates at 0.

Optional Feature:
MULTDIV_EARLY_OUT_EN
- Defined:
  - If early_out=1 on the accept cycle, the counter loads 0, so hilo_commit occurs 1 cycle after md_start.
  - early_out is ignored in all other cycles.
- Undefined: early_out is ignored; the port remains present and latency is always the full parameter value.

Test Plan:
1. MULT (funct 24) valid at cycle 0, defaults → md_start=1 @0; busy=1 @1–4; hilo_commit=1 @4 only; op_signed=1, op_div=0; busy=0 @5.
2. DIVU (funct 27) @0, then MFLO (funct 18) held valid from @3 → stall=1 @3–32; hilo_commit @32; stall=0 @33; op_signed=0, op_div=1.
3. MULTU @0, ADDU (opcode 0, funct 33) valid @2 → stall=0 @2; commit @4 unaffected.
4. DIV @0, flush=1 @10 → busy=0 @11; no hilo_commit through @40. Second case: DIV @0, flush=1 @32 → hilo_commit=0 @32.
5. MULT @0, rst_n=0 asynchronously mid-cycle 2 → all outputs 0 immediately. After release, MULT accepted again with a fresh 4-cycle latency.
6. With MULTDIV_EARLY_OUT_EN: DIV with early_out=1 @0 → hilo_commit @1. Without the macro: same stimulus → hilo_commit @32.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Mult/div sequencing controller: start pulse, latency count, HI/LO commit, stall.
// Optional MULTDIV_EARLY_OUT_EN: early_out on accept collapses latency to 1 cycle.
module multdiv_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    input  logic [5:0] opcode,
    input  logic [5:0] function_code,
    input  logic       early_out,
    input  logic       flush,
    output logic       md_start,
    output logic       op_signed,
    output logic       op_div,
    output logic       busy,
    output logic       stall,
    output logic       hilo_commit
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             div_q, div_d;

    logic is_r, is_md, is_hilo, accept, eo;
    logic start_c, busy_c, stall_c, commit_c;

    assign is_r    = (opcode == 6'd0);
    assign is_md   = is_r && (function_code[5:2] == 4'b0110);
    assign is_hilo = is_md || (is_r && (function_code[5:2] == 4'b0100));
    assign accept  = valid_in && is_md && !flush;

`ifdef MULTDIV_EARLY_OUT_EN
    assign eo = early_out;
`else
    logic unused_early_out;
    assign unused_early_out = early_out;
    assign eo = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sgn_d    = sgn_q;
        div_d    = div_q;
        start_c  = 1'b0;
        busy_c   = 1'b0;
        stall_c  = 1'b0;
        commit_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    start_c = 1'b1;
                    sgn_d   = (function_code == 6'd24) || (function_code == 6'd26);
                    div_d   = function_code[1];
                    if (eo) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = function_code[1] ? DIV_LD : MULT_LD;
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy_c  = 1'b1;
                stall_c = valid_in && is_hilo;
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    commit_c = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Combinational pulses are masked so reset silences them immediately.
    assign md_start    = start_c && rst_n;
    assign busy        = busy_c && rst_n;
    assign stall       = stall_c && rst_n;
    assign hilo_commit = commit_c && rst_n;
    assign op_signed   = sgn_q;
    assign op_div      = div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            div_q   <= div_d;
        end
    end

endmodule
